// File: rtl/bnand_bist.sv
// Built-in self-test sequencer for a single 2-input NAND cell.
// Walks {a,b} = 00,01,10,11 for LOOPS passes and records mismatches.
module bnand_bist #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             nand_y,
   output logic             nand_a,
   output logic             nand_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic [1:0]       fail_vec
);

   localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int LW = $clog2(LOOPS + 1);
   localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYCLES);
   localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

   // With no settle time every vector goes straight to its sample cycle
   localparam state_t FIRST = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;

   state_t        state;
   logic [SW-1:0] cnt;
   logic [LW-1:0] loop;
   logic [1:0]    vec;
   logic          expect_y;
   logic          miss;
   logic          last;

   assign expect_y = ~(vec[1] & vec[0]);
   assign miss     = (nand_y != expect_y);
   assign last     = (vec == 2'd3) && (loop == LOOP_LAST);
   assign nand_a   = vec[1];
   assign nand_b   = vec[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         loop       <= '0;
         vec        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state      <= FIRST;
                  cnt        <= SW'(1);
                  loop       <= '0;
                  vec        <= '0;
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
               end
            end
            SETTLE: begin
               if (cnt == SET_LAST) state <= SAMPLE;
               else                 cnt   <= cnt + SW'(1);
            end
            SAMPLE: begin
               if (miss) begin
                  if (err_count != '1)
                     err_count <= err_count + ERR_W'(1);
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= vec;
                  end
               end
               // vec wraps 11 -> 00, which also parks the outputs at 0
               vec <= vec + 2'd1;
               cnt <= SW'(1);
               if (last) begin
                  state <= FINISH;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !miss;
               end else begin
                  state <= FIRST;
                  if (vec == 2'd3) loop <= loop + LW'(1);
               end
            end
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bnand_bist.sv
// Scoreboard bench for bnand_bist: three instances with different
// parameters, each driven by a NAND model that can be faulted.
module tb_bnand_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [2:0] start, y, a, b, busy, done, pass, fv;
   logic [3:0] e0, e2;
   logic [2:0] e1;
   logic [1:0] v0, v1, v2;
   int         mode [3];

   localparam int SC [3] = '{2, 2, 0};

   int checks = 0;
   int errors = 0;

   typedef struct {
      int dut;
      int len;
      int pass;
      int err;
      int fv;
      int fvec;
   } exp_t;

   exp_t q[$];

   bnand_bist #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(4)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .nand_y(y[0]),
      .nand_a(a[0]), .nand_b(b[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .err_count(e0), .fail_valid(fv[0]), .fail_vec(v0)
   );

   bnand_bist #(.SETTLE_CYCLES(2), .LOOPS(4), .ERR_W(3)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .nand_y(y[1]),
      .nand_a(a[1]), .nand_b(b[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .err_count(e1), .fail_valid(fv[1]), .fail_vec(v1)
   );

   bnand_bist #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(4)) u2 (
      .clk(clk), .rst(rst), .start(start[2]), .nand_y(y[2]),
      .nand_a(a[2]), .nand_b(b[2]), .busy(busy[2]), .done(done[2]),
      .pass(pass[2]), .err_count(e2), .fail_valid(fv[2]), .fail_vec(v2)
   );

   // 0 good NAND, 1 stuck-at-1, 2 stuck-at-0, 3 AND gate
   always_comb begin
      y = '0;
      for (int k = 0; k < 3; k++) begin
         case (mode[k])
            1:       y[k] = 1'b1;
            2:       y[k] = 1'b0;
            3:       y[k] = a[k] & b[k];
            default: y[k] = ~(a[k] & b[k]);
         endcase
      end
   end

   function automatic int errc(int k);
      case (k)
         0:       return int'(e0);
         1:       return int'(e1);
         default: return int'(e2);
      endcase
   endfunction

   function automatic int fvec(int k);
      case (k)
         0:       return int'(v0);
         1:       return int'(v1);
         default: return int'(v2);
      endcase
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset();
      for (int k = 0; k < 3; k++) begin
         chk("rst_a", a[k], 0);
         chk("rst_b", b[k], 0);
         chk("rst_busy", busy[k], 0);
         chk("rst_done", done[k], 0);
         chk("rst_pass", pass[k], 0);
         chk("rst_err", errc(k), 0);
         chk("rst_fail_valid", fv[k], 0);
         chk("rst_fail_vec", fvec(k), 0);
      end
   endtask

   task automatic push(int k, int len, int p, int e, int f, int fvv);
      exp_t x;
      x.dut = k; x.len = len; x.pass = p;
      x.err = e; x.fv = f; x.fvec = fvv;
      q.push_back(x);
   endtask

   task automatic pulse(int k);
      @(negedge clk);
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   task automatic wait_done(int k);
      int n = 0;
      while (n < 600) begin
         @(negedge clk);
         if (done[k]) break;
         n++;
      end
      if (n >= 600) chk("done_timeout", 0, 1);
   endtask

   // Monitor: checks vector sequence, run length and verdicts on done
   initial begin
      int   bl [3];
      logic pb [3];
      logic pd [3];
      exp_t x;
      for (int k = 0; k < 3; k++) begin
         bl[k] = 0; pb[k] = 1'b0; pd[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (pd[k]) chk("idle_after_finish", busy[k], 0);
            if (busy[k] === 1'b1) begin
               if (!pb[k]) bl[k] = 0;
               chk("vector", {a[k], b[k]}, (bl[k] / (SC[k] + 1)) % 4);
               bl[k]++;
            end
            if (done[k] === 1'b1) begin
               chk("busy_in_finish", busy[k], 0);
               if (q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  x = q.pop_front();
                  chk("dut_id", k, x.dut);
                  chk("run_length", bl[k], x.len);
                  chk("pass", pass[k], x.pass);
                  chk("err_count", errc(k), x.err);
                  chk("fail_valid", fv[k], x.fv);
                  chk("fail_vec", fvec(k), x.fvec);
               end
            end
            pb[k] = (busy[k] === 1'b1);
            pd[k] = (done[k] === 1'b1);
         end
      end
   end

   initial begin
      int n;
      rst   = 1'b1;
      start = '0;
      for (int k = 0; k < 3; k++) mode[k] = 0;
      repeat (3) @(negedge clk);
      check_reset();
      rst = 1'b0;

      // good cell, defaults
      push(0, 12, 1, 0, 0, 0);
      pulse(0);
      wait_done(0);

      // start re-pulsed while busy is ignored
      push(0, 12, 1, 0, 0, 0);
      pulse(0);
      repeat (4) @(negedge clk);
      pulse(0);
      wait_done(0);

      // stuck-at-1 only fails vector 11
      mode[0] = 1;
      push(0, 12, 0, 1, 1, 3);
      pulse(0);
      wait_done(0);
      mode[0] = 0;

      // stuck-at-0, four loops: raw 12 errors saturate at 7
      mode[1] = 2;
      push(1, 48, 0, 7, 1, 0);
      pulse(1);
      wait_done(1);

      // AND gate, no settle time: every vector fails
      mode[2] = 3;
      push(2, 4, 0, 4, 1, 0);
      pulse(2);
      wait_done(2);

      // abort during vector 10, no done expected
      pulse(0);
      n = 0;
      while (n < 50 && !(a[0] === 1'b1 && b[0] === 1'b0)) begin
         @(negedge clk);
         n++;
      end
      chk("reach_vec10", n < 50, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset();
      rst = 1'b0;
      repeat (6) @(negedge clk);

      push(0, 12, 1, 0, 0, 0);
      pulse(0);
      wait_done(0);

      // start held high: back-to-back runs
      for (int r = 0; r < 3; r++) push(0, 12, 1, 0, 0, 0);
      @(negedge clk);
      start[0] = 1'b1;
      for (int r = 0; r < 3; r++) begin
         wait_done(0);
         if (r < 2) begin
            @(negedge clk);
            @(negedge clk);
            chk("back_to_back", busy[0], 1);
         end else begin
            start[0] = 1'b0;
         end
      end

      repeat (6) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
